// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the round-robin register-sharing arbiter.
package reg_share_pkg;

    // Arbiter mode: free round-robin or held by one lock owner
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Index width: max(1, clog2(m))
    function automatic int unsigned idw(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/regN_en_D.sv
// N-bit enabled D register with asynchronous active-high clear.
module regN_en_D #(
    parameter int unsigned N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d_in,
    output logic [N-1:0] q
);

    // Load on enable, hold otherwise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d_in;
        end
    end

endmodule

// File: rtl/reg_share_arb_rr.sv
// Round-robin arbiter sharing one N-bit register among M requesters, with capped lock.
module reg_share_arb_rr
    import reg_share_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned M        = 4,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [M-1:0]                req_valid,
    input  logic [M-1:0]                req_lock,
    input  logic [M*N-1:0]              req_data,
    output logic [M-1:0]                req_ready,
    output logic [N-1:0]                d_out,
    output logic [idw(M)-1:0]           owner,
    output logic                        upd,
    output logic                        locked
);

    localparam int unsigned IDW    = idw(M);
    localparam int unsigned CW     = idw(LOCK_MAX + 1);
    localparam bit          LOCK_EN = (LOCK_MAX > 1);

    arb_state_t      state, state_d;
    logic [CW-1:0]   beat_cnt, beat_d;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [IDW-1:0]  xfer_idx;
    logic            xfer;
    logic            lock_sel;
    logic [N-1:0]    d_sel;
    logic [M-1:0]    ready_c;
    logic [IDW:0]    sum;

    // Round-robin search starting at ptr, wrapping explicitly past M-1
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        for (int k = 0; k < M; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(M)) begin
                sum = sum - (IDW+1)'(M);
            end
            if (!grant_any && req_valid[sum]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(sum);
            end
        end
    end

    // Grant vector: lock owner only while locked, nothing during reset
    always_comb begin
        ready_c = '0;
        if (!reset) begin
            if (state == LOCKED) begin
                ready_c[owner] = req_valid[owner];
            end else if (grant_any) begin
                ready_c[grant_idx] = 1'b1;
            end
        end
    end

    assign req_ready = ready_c;
    assign xfer      = |(req_valid & ready_c);
    assign xfer_idx  = (state == LOCKED) ? owner : grant_idx;
    assign lock_sel  = req_lock[xfer_idx];
    assign locked    = (state == LOCKED);

    // Winner data mux (ready is one-hot or zero)
    always_comb begin
        d_sel = '0;
        for (int i = 0; i < M; i++) begin
            if (ready_c[i]) begin
                d_sel = req_data[i*N +: N];
            end
        end
    end

    regN_en_D #(.N(N)) u_reg (
        .clock (clock),
        .reset (reset),
        .en    (xfer),
        .d_in  (d_sel),
        .q     (d_out)
    );

    // Lock FSM next state and beat counter, advanced only on a transfer
    always_comb begin
        state_d = state;
        beat_d  = beat_cnt;
        if (xfer) begin
            case (state)
                IDLE: begin
                    if (lock_sel && LOCK_EN) begin
                        state_d = LOCKED;
                        beat_d  = CW'(1);
                    end
                end
                LOCKED: begin
                    if (lock_sel && ((32'(beat_cnt) + 32'd1) < LOCK_MAX)) begin
                        beat_d = beat_cnt + CW'(1);
                    end else begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_d;
        end
    end

    // Owner, pointer and update pulse; pointer moves past the winner on every transfer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner <= '0;
            ptr   <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= xfer;
            if (xfer) begin
                owner <= xfer_idx;
                ptr   <= (xfer_idx == IDW'(M-1)) ? '0 : xfer_idx + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_share_arb_rr.sv
// Directed table-driven bench for reg_share_arb_rr (M=4, N=8, LOCK_MAX=3).
module tb_reg_share_arb_rr;

    localparam int unsigned N  = 8;
    localparam int unsigned M  = 4;
    localparam int unsigned LM = 3;
    localparam int unsigned NV = 17;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] lock;
        logic [3:0] exp_ready;
        logic [7:0] exp_d;
        logic [1:0] exp_owner;
        logic       exp_upd;
        logic       exp_locked;
    } vec_t;

    logic           clock;
    logic           reset;
    logic [M-1:0]   req_valid;
    logic [M-1:0]   req_lock;
    logic [M*N-1:0] req_data;
    logic [M-1:0]   req_ready;
    logic [N-1:0]   d_out;
    logic [1:0]     owner;
    logic           upd;
    logic           locked;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t vecs [NV];

    reg_share_arb_rr #(.N(N), .M(M), .LOCK_MAX(LM)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_data  (req_data),
        .req_ready (req_ready),
        .d_out     (d_out),
        .owner     (owner),
        .upd       (upd),
        .locked    (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] r, input logic [7:0] d,
                           input logic [1:0] o, input logic u, input logic l);
        chk({tag, " ready"},  32'(req_ready), 32'(r));
        chk({tag, " d_out"},  32'(d_out),     32'(d));
        chk({tag, " owner"},  32'(owner),     32'(o));
        chk({tag, " upd"},    32'(upd),       32'(u));
        chk({tag, " locked"}, 32'(locked),    32'(l));
    endtask

    initial begin
        // valid, lock, ready, d_out, owner, upd, locked (outputs seen before the edge)
        vecs[0]  = '{4'hF, 4'h0, 4'b0001, 8'h00, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 4'h0, 4'b0010, 8'hA0, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{4'hF, 4'h0, 4'b0100, 8'hA1, 2'd1, 1'b1, 1'b0};
        vecs[3]  = '{4'hF, 4'h0, 4'b1000, 8'hA2, 2'd2, 1'b1, 1'b0};
        vecs[4]  = '{4'h4, 4'h0, 4'b0100, 8'hA3, 2'd3, 1'b1, 1'b0};
        vecs[5]  = '{4'h9, 4'h0, 4'b1000, 8'hA2, 2'd2, 1'b1, 1'b0};
        vecs[6]  = '{4'h9, 4'h0, 4'b0001, 8'hA3, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{4'h3, 4'h2, 4'b0010, 8'hA0, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{4'h3, 4'h2, 4'b0010, 8'hA1, 2'd1, 1'b1, 1'b1};
        vecs[9]  = '{4'h3, 4'h2, 4'b0010, 8'hA1, 2'd1, 1'b1, 1'b1};
        vecs[10] = '{4'h3, 4'h2, 4'b0001, 8'hA1, 2'd1, 1'b1, 1'b0};
        vecs[11] = '{4'h2, 4'h2, 4'b0010, 8'hA0, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{4'h1, 4'h0, 4'b0000, 8'hA1, 2'd1, 1'b1, 1'b1};
        vecs[13] = '{4'h1, 4'h0, 4'b0000, 8'hA1, 2'd1, 1'b0, 1'b1};
        vecs[14] = '{4'h2, 4'h0, 4'b0010, 8'hA1, 2'd1, 1'b0, 1'b1};
        vecs[15] = '{4'h0, 4'h0, 4'b0000, 8'hA1, 2'd1, 1'b1, 1'b0};
        vecs[16] = '{4'h0, 4'h0, 4'b0000, 8'hA1, 2'd1, 1'b0, 1'b0};

        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        req_lock  = 4'h0;
        reset     = 1'b1;

        // Reset held with every requester valid
        repeat (2) begin
            @(posedge clock);
            #1;
            chk_all("reset", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        end
        req_valid = 4'h0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Directed vectors: round-robin, wrap, capped lock, owner stall
        for (int v = 0; v < NV; v++) begin
            req_valid = vecs[v].valid;
            req_lock  = vecs[v].lock;
            #1;
            chk_all($sformatf("vec%0d", v), vecs[v].exp_ready, vecs[v].exp_d,
                    vecs[v].exp_owner, vecs[v].exp_upd, vecs[v].exp_locked);
            @(posedge clock);
            #1;
        end

        // Enter lock on requester 1 (ptr=2 searches 2,3,0,1)
        req_valid = 4'h2;
        req_lock  = 4'h2;
        #1;
        chk("relock ready", 32'(req_ready), 32'h2);
        @(posedge clock);
        #2;
        chk("relock locked", 32'(locked), 32'h1);
        chk("relock d_out",  32'(d_out),  32'hA1);

        // Asynchronous reset between edges clears everything at once
        reset = 1'b1;
        #1;
        chk_all("midlock reset", 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0);
        req_valid = 4'hF;
        req_lock  = 4'h0;
        #1;
        chk("reset hold ready", 32'(req_ready), 32'h0);
        #1 reset = 1'b0;
        #1;
        chk_all("post reset", 4'b0001, 8'h00, 2'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        chk_all("post reset beat", 4'b0010, 8'hA0, 2'd0, 1'b1, 1'b0);
        req_valid = 4'h0;
        @(posedge clock);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
